// File: rtl/mcp3202_pkg.sv
// Shared types and constants for the MCP3202 scan controller.
// Holds the FSM encoding, channel indices and frame-period helpers.
package mcp3202_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_ISSUE,
        S_CONVERT,
        S_STORE
    } scan_state_t;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    function automatic int unsigned frame_cnts(input int unsigned fclk, input int unsigned fsmpl);
        return fclk / fsmpl;
    endfunction

    function automatic int frame_cnt_w(input int unsigned fclk, input int unsigned fsmpl);
        return (frame_cnts(fclk, fsmpl) > 1) ? $clog2(frame_cnts(fclk, fsmpl)) : 1;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame timer: counts 0..PERIOD-1 while enabled and
// emits a one-cycle tick on the last count; held at zero when disabled.
module frame_tick_gen #(
    parameter int unsigned PERIOD = 1000,
    parameter int          CW     = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);
    localparam logic [CW-1:0] TOP = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!enable || cnt == TOP)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = enable && (cnt == TOP);

endmodule

// File: rtl/mcp3202_scan_ctrl.sv
// Frame-based scan controller for an MCP3202 conversion engine: converts each
// enabled channel per frame and buffers results in valid/ready holding registers.
module mcp3202_scan_ctrl
    import mcp3202_pkg::*;
#(
    parameter int unsigned FCLK        = 100_000_000,
    parameter int unsigned FSMPL       = 500,
    parameter logic [1:0]  CH_MASK     = 2'b11,
    parameter bit          SGL         = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        conv_start,
    output logic        conv_sgl,
    output logic        conv_odd,
    input  logic        conv_busy,
    input  logic        conv_done,
    input  logic [11:0] conv_data,
    output logic [11:0] ch0_data,
    output logic [11:0] ch1_data,
    output logic        ch0_valid,
    output logic        ch1_valid,
    input  logic        ch0_ready,
    input  logic        ch1_ready,
    output logic [1:0]  ch_ovr,
    output logic        frame_ovr,
    output logic        timeout_err,
    input  logic        err_clr
);
    localparam int unsigned   FRAME_CNTS = frame_cnts(FCLK, FSMPL);
    localparam int            FRAME_W    = frame_cnt_w(FCLK, FSMPL);
    localparam int            TW         = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] T_LAST     = TW'(TIMEOUT_CYC - 1);
    localparam logic          FIRST_CH   = CH_MASK[CH0] ? CH0 : CH1;

    if (CH_MASK == 2'b00) begin : g_bad_mask
        $error("mcp3202_scan_ctrl: CH_MASK must enable at least one channel");
    end

    scan_state_t      state, state_nx;
    logic             ptr, ptr_nx, ptr_ld;
    logic [TW-1:0]    tcnt;
    logic [11:0]      res;
    logic             tick, tmo_hit, more;
    logic [1:0][11:0] data_q;
    logic [1:0]       valid_q, ready, store_sel;

    frame_tick_gen #(
        .PERIOD (FRAME_CNTS),
        .CW     (FRAME_W)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    // A higher enabled channel remains in this frame only when sitting on CH0.
    assign more     = (ptr == CH0) && CH_MASK[CH1];
    assign conv_sgl = SGL;
    assign conv_odd = ptr;

    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        ptr_ld     = 1'b0;
        conv_start = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            S_IDLE:      if (enable) state_nx = S_WAIT_TICK;
            S_WAIT_TICK: begin
                if (tick) begin
                    ptr_ld   = 1'b1;
                    ptr_nx   = FIRST_CH;
                    state_nx = S_ISSUE;
                end else if (!enable) begin
                    state_nx = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (!enable) begin
                    state_nx = S_IDLE;
                end else if (!conv_busy) begin
                    conv_start = 1'b1;
                    state_nx   = S_CONVERT;
                end
            end
            S_CONVERT, S_STORE: begin
                if (state == S_CONVERT && conv_done) begin
                    state_nx = S_STORE;
                end else if (state == S_STORE || tcnt == T_LAST) begin
                    tmo_hit = (state == S_CONVERT);
                    if (enable && more) begin
                        ptr_ld   = 1'b1;
                        ptr_nx   = CH1;
                        state_nx = S_ISSUE;
                    end else begin
                        state_nx = enable ? S_WAIT_TICK : S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ptr   <= CH0;
            tcnt  <= '0;
            res   <= '0;
        end else begin
            state <= state_nx;
            if (ptr_ld) ptr <= ptr_nx;
            if (conv_start) tcnt <= '0;
            else if (state == S_CONVERT) tcnt <= tcnt + 1'b1;
            if (state == S_CONVERT && conv_done) res <= conv_data;
        end
    end

    assign ready     = {ch1_ready, ch0_ready};
    assign store_sel = (state != S_STORE) ? 2'b00 : (ptr ? 2'b10 : 2'b01);

    // A store always wins over a same-cycle handshake so fresh data is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= '0;
            ch_ovr  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (store_sel[i]) begin
                    data_q[i]  <= res;
                    valid_q[i] <= 1'b1;
                end else if (valid_q[i] && ready[i]) begin
                    valid_q[i] <= 1'b0;
                end
                if (store_sel[i] && valid_q[i] && !ready[i]) ch_ovr[i] <= 1'b1;
                else if (err_clr)                             ch_ovr[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_ovr   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (tick && state != S_WAIT_TICK) frame_ovr <= 1'b1;
            else if (err_clr)                 frame_ovr <= 1'b0;
            if (tmo_hit)      timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end

    assign ch0_data  = data_q[0];
    assign ch1_data  = data_q[1];
    assign ch0_valid = valid_q[0];
    assign ch1_valid = valid_q[1];

endmodule

// File: doc/mcp3202_scan_ctrl.md
# mcp3202_scan_ctrl

Scan controller that schedules conversions on the MCP3202 ADC front end. A frame timer at `FSMPL` starts a frame, and each frame converts every enabled channel in ascending order. The controller drives channel and mode selects to a start/done-style MCP3202 conversion engine and buffers each result in a per-channel holding register. Results leave through valid/ready streams, with sticky error flags for overruns and timeouts.

## Interface
- `FCLK`, 100e6, input clock frequency in Hz
- `FSMPL`, 500, frame (per-channel sample) rate in Hz; frame period `FRAME_CNTS = FCLK/FSMPL` cycles
- `CH_MASK`, 2'b11, enabled channels; bit0 = CH0, bit1 = CH1; 2'b00 is illegal (elaboration error)
- `SGL`, 1, single-ended (1) or pseudo-differential (0) mode, forwarded to the engine
- `TIMEOUT_CYC`, 20000, maximum cycles from `conv_start` to `conv_done`
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `enable`  in  1  level; scanning runs while high
- `conv_start`  out  1  one-cycle pulse requesting a conversion
- `conv_sgl`  out  1  mode select, equals `SGL`, stable while `conv_busy`
- `conv_odd`  out  1  channel select for the current conversion, held from `conv_start` until `conv_done`
- `conv_busy`  in  1  engine busy; `conv_start` is only issued when low
- `conv_done`  in  1  one-cycle pulse; `conv_data` is valid in the same cycle
- `conv_data`  in  12  conversion result
- `ch0_data`, `ch1_data`  out  12  held results
- `ch0_valid`, `ch1_valid`  out  1  result available
- `ch0_ready`, `ch1_ready`  in  1  consumer accepts the result
- `ch_ovr`  out  2  sticky flag per channel: an unread result was overwritten
- `frame_ovr`  out  1  sticky flag: a frame tick arrived while the previous frame was still running
- `timeout_err`  out  1  sticky flag: `conv_done` was missing after `TIMEOUT_CYC` cycles
- `err_clr`  in  1  clears all sticky flags

## Operation
- **Frame timer**
  - Counts 0..`FRAME_CNTS`-1 while `enable` is high and wraps at the top.
  - The tick fires at count `FRAME_CNTS`-1.
  - Held at 0 while `enable` is low.
- **States:** IDLE, WAIT_TICK, ISSUE, CONVERT, STORE.
- **IDLE**
  - `enable` high → WAIT_TICK.
- **WAIT_TICK**
  - On tick, load the channel pointer with the lowest enabled channel, then → ISSUE.
  - `enable` low → IDLE.
- **ISSUE**
  - When `conv_busy` is low: pulse `conv_start`, drive `conv_odd` = pointer, clear the timeout counter, then → CONVERT.
  - Otherwise wait in ISSUE.
- **CONVERT**
  - `conv_done` → latch `conv_data`, then → STORE.
  - Timeout counter reaches `TIMEOUT_CYC`-1 → set `timeout_err`, discard the channel, then go to the next channel's ISSUE or to WAIT_TICK.
- **STORE**
  - Write the latched result to `chN_data` and set `chN_valid`.
  - If another channel is enabled above the pointer, advance the pointer and → ISSUE.
  - Otherwise → WAIT_TICK, or → IDLE if `enable` is low.
- **Enable deasserted mid-frame**
  - The current conversion completes and is stored.
  - The remaining channels of the frame are skipped.
- **Output handshake**
  - `chN_valid` clears on `valid & ready`.
  - Store while valid and not ready: data is overwritten, `ch_ovr[N]` is set, valid stays 1.
  - Store and handshake in the same cycle: new data is loaded, valid stays 1, no overrun.
- **Tick while not in WAIT_TICK**
  - Sets `frame_ovr`.
  - The tick is dropped; there is no queued frame.
- **Error flags**
  - `err_clr` clears all sticky flags.
  - If `err_clr` coincides with a set event, the set wins.

## Timing
- Reset values:
  - State is IDLE; all counters are 0.
  - `conv_start` = 0, `conv_odd` = 0, `chN_data` = 0, `chN_valid` = 0, all flags 0.
  - `conv_sgl` = `SGL` at all times.
- Tick → `conv_start`: 1 cycle (WAIT_TICK→ISSUE), pulse in the 2nd cycle if the engine is idle.
- `conv_done` → `chN_valid` high: 2 cycles (CONVERT→STORE, register update).
- Back-to-back channels: the next `conv_start` comes 2 cycles after the previous `conv_done`, gated by `conv_busy`.
- Asynchronous reset mid-conversion:
  - Immediate return to reset values.
  - A late `conv_done` arriving in IDLE is ignored.
- `conv_done` outside CONVERT is ignored.

## Structure
- Package `mcp3202_pkg`:
  - State encoding constants.
  - The `CH0`/`CH1` index constants.
  - A function computing `FRAME_CNTS` with its counter width (`$clog2`).
- Sub-module `frame_tick_gen` provides the frame timer: parameterised period, `enable` in, one-cycle `tick` out.
- Per-channel holding registers and the FSM stay in the top module.

## Test plan
- Fast-sim setup for all scenarios: `FCLK`=1e6, `FSMPL`=1000, so `FRAME_CNTS`=1000.
- Both channels enabled, engine model returns 12'h123 for odd=0 and 12'hABC for odd=1 after 50 cycles:
  - `ch0_data`=0x123, then `ch1_data`=0xABC every 1000 cycles.
  - `conv_odd` sequence is 0,1; no flags set.
- `CH_MASK`=2'b10:
  - Only `conv_odd`=1 conversions occur.
  - `ch0_valid` never rises.
- `ch0_ready` held low for 2 frames:
  - `ch_ovr[0]`=1 after the second store, and `ch0_data` holds the newest value.
  - `err_clr` pulse → flag 0.
- Engine never asserts `conv_done`:
  - `timeout_err`=1 exactly `TIMEOUT_CYC` cycles after `conv_start`.
  - Then CH1 is issued.
- Engine latency 1200 cycles:
  - `frame_ovr`=1.
  - Only one `conv_start` per completed conversion.
- `rst_n` low during CONVERT, followed by a stray `conv_done`:
  - All outputs return to reset values.
  - No valid is asserted.
